// File: rtl/pipe_control_if.sv
// Stage-status and stage-control bundle between the pipeline datapath (master) and pipe_control (slave).
// Also carries the FSM state, halt status and performance counters back to the pipeline side.
interface pipe_control_if;
   logic [3:0]  D_icode;
   logic [3:0]  d_srcA;
   logic [3:0]  d_srcB;
   logic [3:0]  E_icode;
   logic [3:0]  E_dstM;
   logic        e_Cnd;
   logic [3:0]  M_icode;
   logic [3:0]  m_stat;
   logic [3:0]  W_icode;
   logic [3:0]  W_stat;

   logic        F_stall;
   logic        D_stall;
   logic        D_bubble;
   logic        E_bubble;
   logic        M_bubble;
   logic        W_stall;

   logic [1:0]  state;
   logic        halted;
   logic [3:0]  halt_code;
   logic [31:0] cycle_cnt;
   logic [31:0] retire_cnt;
   logic [15:0] stall_cnt;
   logic [15:0] mispred_cnt;

   modport master (
      output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
             M_icode, m_stat, W_icode, W_stat,
      input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
             state, halted, halt_code, cycle_cnt, retire_cnt, stall_cnt, mispred_cnt
   );

   modport slave (
      input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
             M_icode, m_stat, W_icode, W_stat,
      output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
             state, halted, halt_code, cycle_cnt, retire_cnt, stall_cnt, mispred_cnt
   );
endinterface

// File: rtl/pipe_control.sv
// Pipeline hazard control: combinational stall/bubble decode, exception drain/halt FSM, saturating perf counters.
// Stage controls are zero latency; state, halt_code and counters update on the rising clk edge.
module pipe_control (
   input  logic          clk,
   input  logic          rst,
   pipe_control_if.slave pif
);
   localparam logic [3:0] S_AOK    = 4'h1;
   localparam logic [3:0] S_HLT    = 4'h2;
   localparam logic [3:0] S_ADR    = 4'h3;
   localparam logic [3:0] S_INS    = 4'h4;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_POPQ   = 4'hB;
   localparam logic [3:0] R_NONE   = 4'hF;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2,
      RSVD   = 2'd3
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [3:0]  halt_code_q;
   logic [31:0] cycle_q;
   logic [31:0] retire_q;
   logic [15:0] stall_q;
   logic [15:0] mispred_q;

   logic load_use;
   logic ret_pend;
   logic mispred;
   logic m_exc;
   logic w_exc;
   logic active;

   assign load_use = ((pif.E_icode == I_MRMOVQ) || (pif.E_icode == I_POPQ)) &&
                     (pif.E_dstM != R_NONE) &&
                     ((pif.E_dstM == pif.d_srcA) || (pif.E_dstM == pif.d_srcB));
   assign ret_pend = (pif.D_icode == I_RET) || (pif.E_icode == I_RET) || (pif.M_icode == I_RET);
   assign mispred  = (pif.E_icode == I_JXX) && !pif.e_Cnd;
   assign m_exc    = (pif.m_stat == S_HLT) || (pif.m_stat == S_ADR) || (pif.m_stat == S_INS);
   assign w_exc    = (pif.W_stat == S_HLT) || (pif.W_stat == S_ADR) || (pif.W_stat == S_INS);

   // The unreachable encoding 2'd3 shares bit 1 with HALTED, so it behaves as HALTED everywhere.
   assign active = !state_q[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         halt_code_q <= S_AOK;
      end else begin
         state_q <= state_d;
         if (active && w_exc) begin
            halt_code_q <= pif.W_stat;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      pif.F_stall  = 1'b0;
      pif.D_stall  = 1'b0;
      pif.D_bubble = 1'b0;
      pif.E_bubble = 1'b0;
      pif.M_bubble = 1'b0;
      pif.W_stall  = 1'b0;
      case (state_q)
         RUN, DRAIN: begin
            if (w_exc) begin
               state_d = HALTED;
            end else if (m_exc) begin
               state_d = DRAIN;
            end
            pif.F_stall  = load_use | ret_pend;
            pif.D_stall  = load_use;
            pif.D_bubble = mispred | (ret_pend & !load_use);
            pif.E_bubble = mispred | load_use;
            pif.M_bubble = m_exc | w_exc;
            pif.W_stall  = w_exc;
            // While draining, nothing new enters and nothing reaches memory.
            if (state_q == DRAIN) begin
               pif.F_stall  = 1'b1;
               pif.D_stall  = 1'b1;
               pif.M_bubble = 1'b1;
            end
         end
         default: begin
            state_d      = HALTED;
            pif.F_stall  = 1'b1;
            pif.D_stall  = 1'b1;
            pif.M_bubble = 1'b1;
            pif.W_stall  = 1'b1;
         end
      endcase
      // Reset loads bubbles into the downstream stage registers.
      if (rst) begin
         pif.F_stall  = 1'b0;
         pif.D_stall  = 1'b0;
         pif.W_stall  = 1'b0;
         pif.D_bubble = 1'b1;
         pif.E_bubble = 1'b1;
         pif.M_bubble = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_q   <= '0;
         retire_q  <= '0;
         stall_q   <= '0;
         mispred_q <= '0;
      end else begin
         if (active && (cycle_q != '1)) begin
            cycle_q <= cycle_q + 32'd1;
         end
         if (active && (pif.W_icode != I_NOP) && (pif.W_stat == S_AOK) && (retire_q != '1)) begin
            retire_q <= retire_q + 32'd1;
         end
         if ((state_q == RUN) && load_use && (stall_q != '1)) begin
            stall_q <= stall_q + 16'd1;
         end
         if (active && mispred && (mispred_q != '1)) begin
            mispred_q <= mispred_q + 16'd1;
         end
      end
   end

   assign pif.state       = state_q;
   assign pif.halted      = state_q[1];
   assign pif.halt_code   = halt_code_q;
   assign pif.cycle_cnt   = cycle_q;
   assign pif.retire_cnt  = retire_q;
   assign pif.stall_cnt   = stall_q;
   assign pif.mispred_cnt = mispred_q;
endmodule

// File: tb/tb_pipe_control.sv
// Bench for pipe_control: directed vector table, hand sequences for drain/halt/reset/saturation,
// and a randomized run checked against a behavioural model of the control rules.
module tb_pipe_control;
   logic clk = 1'b0;
   logic rst = 1'b1;

   pipe_control_if pif ();

   pipe_control dut (
      .clk (clk),
      .rst (rst),
      .pif (pif)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] d_ic;
      logic [3:0] sa;
      logic [3:0] sb;
      logic [3:0] e_ic;
      logic [3:0] e_dm;
      logic       cnd;
      logic [3:0] m_ic;
      logic [3:0] ms;
      logic [3:0] w_ic;
      logic [3:0] ws;
   } in_t;

   typedef struct {
      string      name;
      in_t        i;
      logic [5:0] exp;   // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
   } vec_t;

   int total = 0;
   int bad   = 0;

   // Behavioural model: mode 0 run, 1 drain, 2 halted.
   int          m_mode = 0;
   logic [3:0]  m_hc   = 4'h1;
   longint      m_cyc  = 0;
   longint      m_ret  = 0;
   longint      m_stl  = 0;
   longint      m_mis  = 0;

   function automatic in_t mk(logic [3:0] d_ic, logic [3:0] sa, logic [3:0] sb, logic [3:0] e_ic,
                              logic [3:0] e_dm, logic cnd, logic [3:0] m_ic, logic [3:0] ms,
                              logic [3:0] w_ic, logic [3:0] ws);
      in_t v;
      v.d_ic = d_ic; v.sa = sa; v.sb = sb; v.e_ic = e_ic; v.e_dm = e_dm;
      v.cnd = cnd; v.m_ic = m_ic; v.ms = ms; v.w_ic = w_ic; v.ws = ws;
      return v;
   endfunction

   function automatic bit is_exc(logic [3:0] s);
      return (s == 4'h2) || (s == 4'h3) || (s == 4'h4);
   endfunction

   function automatic bit h_lu();
      bit src_hit;
      src_hit = (pif.E_dstM == pif.d_srcA) || (pif.E_dstM == pif.d_srcB);
      return ((pif.E_icode == 4'h5) || (pif.E_icode == 4'hB)) && (pif.E_dstM != 4'hF) && src_hit;
   endfunction

   function automatic bit h_rp();
      return (pif.D_icode == 4'h9) || (pif.E_icode == 4'h9) || (pif.M_icode == 4'h9);
   endfunction

   function automatic bit h_mp();
      return (pif.E_icode == 4'h7) && !pif.e_Cnd;
   endfunction

   function automatic longint sat(longint v, longint maxv);
      return (v < maxv) ? v + 1 : v;
   endfunction

   function automatic logic [5:0] exp_outs();
      bit lu, rp, mp, me, we;
      logic [5:0] r;
      lu = h_lu(); rp = h_rp(); mp = h_mp();
      me = is_exc(pif.m_stat); we = is_exc(pif.W_stat);
      if (rst) return 6'b001110;
      if (m_mode == 2) return 6'b110011;
      r = {lu | rp, lu, mp | (rp & !lu), mp | lu, me | we, we};
      if (m_mode == 1) r = r | 6'b110010;
      return r;
   endfunction

   function automatic logic [5:0] dut_outs();
      return {pif.F_stall, pif.D_stall, pif.D_bubble, pif.E_bubble, pif.M_bubble, pif.W_stall};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode = 0; m_hc = 4'h1;
         m_cyc = 0; m_ret = 0; m_stl = 0; m_mis = 0;
      end else if (m_mode != 2) begin
         m_cyc = sat(m_cyc, 64'hFFFF_FFFF);
         if (pif.W_icode != 4'h1 && pif.W_stat == 4'h1) m_ret = sat(m_ret, 64'hFFFF_FFFF);
         if (m_mode == 0 && h_lu()) m_stl = sat(m_stl, 64'hFFFF);
         if (h_mp()) m_mis = sat(m_mis, 64'hFFFF);
         if (is_exc(pif.W_stat)) begin
            m_mode = 2;
            m_hc   = pif.W_stat;
         end else if (m_mode == 0 && is_exc(pif.m_stat)) begin
            m_mode = 1;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".ctl"},       32'(dut_outs()),        32'(exp_outs()));
      chk({tag, ".state"},     32'(pif.state),         32'(m_mode));
      chk({tag, ".halted"},    32'(pif.halted),        32'(m_mode == 2));
      chk({tag, ".halt_code"}, 32'(pif.halt_code),     32'(m_hc));
      chk({tag, ".cycle"},     pif.cycle_cnt,          32'(m_cyc));
      chk({tag, ".retire"},    pif.retire_cnt,         32'(m_ret));
      chk({tag, ".stall"},     32'(pif.stall_cnt),     32'(m_stl));
      chk({tag, ".mispred"},   32'(pif.mispred_cnt),   32'(m_mis));
   endtask

   task automatic drive(input in_t v);
      pif.D_icode = v.d_ic; pif.d_srcA = v.sa; pif.d_srcB = v.sb;
      pif.E_icode = v.e_ic; pif.E_dstM = v.e_dm; pif.e_Cnd = v.cnd;
      pif.M_icode = v.m_ic; pif.m_stat = v.ms;
      pif.W_icode = v.w_ic; pif.W_stat = v.ws;
   endtask

   function automatic logic [3:0] rnd_stat(int pct_exc);
      logic [3:0] pool [4];
      pool[0] = 4'h0; pool[1] = 4'h2; pool[2] = 4'h3; pool[3] = 4'h4;
      if ($urandom_range(0, 99) < pct_exc) return pool[$urandom_range(0, 3)];
      return 4'h1;
   endfunction

   function automatic in_t rnd_in();
      logic [3:0] ic [8];
      in_t v;
      ic[0] = 4'h0; ic[1] = 4'h1; ic[2] = 4'h5; ic[3] = 4'h6;
      ic[4] = 4'h7; ic[5] = 4'h9; ic[6] = 4'hB; ic[7] = 4'h2;
      v.d_ic = ic[$urandom_range(0, 7)];
      v.sa   = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 4));
      v.sb   = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 4));
      v.e_ic = ic[$urandom_range(0, 7)];
      v.e_dm = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 4));
      v.cnd  = 1'($urandom_range(0, 1));
      v.m_ic = ic[$urandom_range(0, 7)];
      v.ms   = rnd_stat(3);
      v.w_ic = ic[$urandom_range(0, 7)];
      v.ws   = rnd_stat(2);
      return v;
   endfunction

   initial begin
      vec_t tbl [11];
      in_t  nop, lu_v, v;
      logic [31:0] sv_cyc, sv_ret;

      nop  = mk(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h1, 4'h1, 4'h1, 4'h1);
      lu_v = mk(4'h6, 4'hF, 4'h2, 4'h5, 4'h2, 1'b0, 4'h1, 4'h1, 4'h1, 4'h1);

      tbl[0]  = '{"all_nop",      nop,                                                               6'b000000};
      tbl[1]  = '{"lu_srcB",      lu_v,                                                              6'b110100};
      tbl[2]  = '{"lu_popq_srcA", mk(4'h6, 4'h4, 4'hF, 4'hB, 4'h4, 1'b0, 4'h1, 4'h1, 4'h1, 4'h1), 6'b110100};
      tbl[3]  = '{"dst_none",     mk(4'h6, 4'hF, 4'h3, 4'h5, 4'hF, 1'b0, 4'h1, 4'h1, 4'h1, 4'h1), 6'b000000};
      tbl[4]  = '{"mispred",      mk(4'h6, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 4'h1, 4'h1, 4'h1), 6'b001100};
      tbl[5]  = '{"jxx_taken",    mk(4'h6, 4'hF, 4'hF, 4'h7, 4'hF, 1'b1, 4'h1, 4'h1, 4'h1, 4'h1), 6'b000000};
      tbl[6]  = '{"ret_in_D",     mk(4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h1, 4'h1, 4'h1, 4'h1), 6'b101000};
      tbl[7]  = '{"ret_in_M",     mk(4'h6, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h9, 4'h1, 4'h1, 4'h1), 6'b101000};
      tbl[8]  = '{"lu_and_ret",   mk(4'h9, 4'h4, 4'hF, 4'hB, 4'h4, 1'b0, 4'h1, 4'h1, 4'h1, 4'h1), 6'b110100};
      tbl[9]  = '{"mp_and_ret",   mk(4'h9, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 4'h1, 4'h1, 4'h1), 6'b101100};
      tbl[10] = '{"mrmov_nohit",  mk(4'h6, 4'h2, 4'h4, 4'h5, 4'h3, 1'b0, 4'h1, 4'h1, 4'h1, 4'h1), 6'b000000};

      // Reset state
      drive(nop);
      #12;
      chk("rst.ctl",    32'(dut_outs()),  32'h0E);
      chk("rst.state",  32'(pif.state),   32'd0);
      chk("rst.halted", 32'(pif.halted),  32'd0);
      chk("rst.hcode",  32'(pif.halt_code), 32'h1);
      chk("rst.cycle",  pif.cycle_cnt,    32'd0);
      check_all("rst");

      // Load-use: stall_cnt 0 -> 1 after one edge
      @(negedge clk); rst = 1'b0; drive(lu_v);
      #1; chk("lu.ctl", 32'(dut_outs()), 32'h34); chk("lu.stall0", 32'(pif.stall_cnt), 32'd0);
      @(negedge clk); #1; chk("lu.stall1", 32'(pif.stall_cnt), 32'd1);

      // Mispredict, then taken branch
      drive(tbl[4].i);
      #1; chk("mp.ctl", 32'(dut_outs()), 32'h0C); chk("mp.cnt0", 32'(pif.mispred_cnt), 32'd0);
      @(negedge clk); drive(tbl[5].i);
      #1; chk("taken.ctl", 32'(dut_outs()), 32'h00); chk("mp.cnt1", 32'(pif.mispred_cnt), 32'd1);
      @(negedge clk); #1; chk("mp.cnt_hold", 32'(pif.mispred_cnt), 32'd1);

      // Vector table
      for (int k = 0; k < 11; k++) begin
         @(negedge clk); drive(tbl[k].i);
         #1; chk(tbl[k].name, 32'(dut_outs()), 32'(tbl[k].exp));
         check_all(tbl[k].name);
      end

      // RET walking D -> E -> M, then RET alongside a load-use
      @(negedge clk); drive(mk(4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h1, 4'h1, 4'h1, 4'h1));
      #1; chk("retD.FDb", 32'({pif.F_stall, pif.D_bubble}), 32'h3);
      @(negedge clk); drive(mk(4'h1, 4'hF, 4'hF, 4'h9, 4'hF, 1'b0, 4'h1, 4'h1, 4'h1, 4'h1));
      #1; chk("retE.FDb", 32'({pif.F_stall, pif.D_bubble}), 32'h3);
      @(negedge clk); drive(mk(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h9, 4'h1, 4'h1, 4'h1));
      #1; chk("retM.FDb", 32'({pif.F_stall, pif.D_bubble}), 32'h3);
      @(negedge clk); drive(mk(4'h9, 4'h4, 4'hF, 4'hB, 4'h4, 1'b0, 4'h1, 4'h1, 4'h1, 4'h1));
      #1; chk("retlu.DbEb", 32'({pif.D_bubble, pif.E_bubble}), 32'h1);
      check_all("ret_seq");

      // Retire counting after a reset pulse
      @(negedge clk); rst = 1'b1; #1; rst = 1'b0;
      v = nop; v.w_ic = 4'h6; drive(v);
      repeat (3) @(negedge clk);
      drive(nop);
      @(negedge clk); #1; chk("retire3", pif.retire_cnt, 32'd3);
      check_all("retire");

      // Exception drain then halt
      v = nop; v.ms = 4'h3; drive(v);
      @(negedge clk); #1;
      chk("drain.state", 32'(pif.state), 32'd1);
      chk("drain.FsMb", 32'({pif.F_stall, pif.D_stall, pif.M_bubble}), 32'h7);
      check_all("drain");
      v = nop; v.ws = 4'h3; drive(v);
      #1; chk("drain.wexc.Ws", 32'(pif.W_stall), 32'd1);
      @(negedge clk); #1;
      chk("halt.state", 32'(pif.state), 32'd2);
      chk("halt.halted", 32'(pif.halted), 32'd1);
      chk("halt.code", 32'(pif.halt_code), 32'h3);
      chk("halt.Ws", 32'(pif.W_stall), 32'd1);
      check_all("halt");
      sv_cyc = pif.cycle_cnt;
      sv_ret = pif.retire_cnt;
      for (int k = 0; k < 10; k++) begin
         v = rnd_in(); v.w_ic = 4'h6; v.ws = 4'h1;
         drive(v);
         @(negedge clk); #1;
         chk("halt.cyc_frozen", pif.cycle_cnt, sv_cyc);
         chk("halt.ret_frozen", pif.retire_cnt, sv_ret);
         chk("halt.ctl", 32'(dut_outs()), 32'h33);
      end

      // Asynchronous reset between edges while halted
      #2; rst = 1'b1; #1;
      chk("arst.state", 32'(pif.state), 32'd0);
      chk("arst.halted", 32'(pif.halted), 32'd0);
      chk("arst.code", 32'(pif.halt_code), 32'h1);
      chk("arst.cnts", pif.cycle_cnt | pif.retire_cnt, 32'd0);
      chk("arst.ctl", 32'(dut_outs()), 32'h0E);
      @(negedge clk); rst = 1'b0; drive(lu_v);
      @(negedge clk); #1;
      chk("arst.first_edge_run", 32'({pif.state, pif.stall_cnt}), 32'h1);
      check_all("arst_post");

      // Randomized run against the model
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 99) < 2);
         drive(rnd_in());
         #1; check_all("rnd");
      end

      // Saturation of the 16-bit stall counter
      @(negedge clk); rst = 1'b1; #1; rst = 1'b0; drive(lu_v);
      repeat (65540) @(negedge clk);
      #1;
      chk("sat.stall", 32'(pif.stall_cnt), 32'h0000_FFFF);
      chk("sat.cycle", pif.cycle_cnt, 32'd65540);
      check_all("sat");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pipe_control.md
PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-002 The block SHALL have these inputs: D_icode 4; d_srcA 4; d_srcB 4; E_icode 4; E_dstM 4; e_Cnd 1 (branch taken); M_icode 4; m_stat 4; W_icode 4; W_stat 4.
REQ-003 The block SHALL have these stage-control outputs: F_stall 1; D_stall 1; D_bubble 1; E_bubble 1; M_bubble 1; W_stall 1.
REQ-004 The block SHALL have these status outputs: state 2; halted 1; halt_code 4; cycle_cnt 32; retire_cnt 32; stall_cnt 16; mispred_cnt 16.
REQ-005 The block SHALL use these encodings:
- Status: AOK=4'h1, HLT=4'h2, ADR=4'h3, INS=4'h4.
- icode: HALT=0, NOP=1, JXX=7, MRMOVQ=5, RET=9, POPQ=B.
- Register "none" = 4'hF.

Function
REQ-006 Hazard terms SHALL be computed combinationally:
- load_use = (E_icode in {MRMOVQ,POPQ}) && E_dstM != F && (E_dstM==d_srcA || E_dstM==d_srcB).
- ret_pend = RET in {D_icode,E_icode,M_icode}.
- mispred = (E_icode==JXX) && !e_Cnd.
- m_exc = m_stat in {HLT,ADR,INS}.
- w_exc = W_stat in {HLT,ADR,INS}.
REQ-007 In RUN, outputs SHALL be combinational, with zero latency:
- F_stall = load_use | ret_pend
- D_stall = load_use
- D_bubble = mispred | (ret_pend & !load_use)
- E_bubble = mispred | load_use
- M_bubble = m_exc | w_exc
- W_stall = w_exc
REQ-008 When load_use and ret_pend are both true, the outputs SHALL be F_stall=1, D_stall=1, E_bubble=1, D_bubble=0.
REQ-009 When mispred and ret_pend are both true, the outputs SHALL be D_bubble=1, E_bubble=1, F_stall=1.
REQ-010 The state machine SHALL use RUN=2'd0, DRAIN=2'd1 and HALTED=2'd2; 2'd3 SHALL be unreachable and SHALL decode as HALTED.
REQ-011 RUN SHALL go to DRAIN on the clock edge at which m_exc=1 and w_exc=0.
REQ-012 RUN or DRAIN SHALL go to HALTED on the clock edge at which w_exc=1, with halt_code <= W_stat at that edge; w_exc takes priority over m_exc.
REQ-013 In DRAIN, all outputs SHALL follow REQ-007, with F_stall and D_stall forced to 1 and M_bubble forced to 1.
REQ-014 HALTED SHALL be sticky until rst.
- Outputs: F_stall=D_stall=W_stall=1, M_bubble=1, D_bubble=E_bubble=0, halted=1.
- Counters and halt_code frozen.
REQ-015 cycle_cnt SHALL increment by 1 on every clock edge in RUN or DRAIN.
REQ-016 retire_cnt SHALL increment when W_icode!=NOP, W_stat==AOK and the state is not HALTED.
REQ-017 stall_cnt SHALL increment on each edge in RUN with load_use=1.
REQ-018 mispred_cnt SHALL increment on each edge in RUN or DRAIN with mispred=1.
REQ-019 All counters SHALL saturate at all-ones and never wrap.

Reset
REQ-020 While rst=1, asynchronously and independent of clk, the block SHALL force state=RUN, halted=0, halt_code=AOK and all counters=0.
REQ-021 While rst=1, the block SHALL force F_stall=D_stall=W_stall=0 and D_bubble=E_bubble=M_bubble=1, so that downstream registers load bubbles.
REQ-022 Reset asserted in any state, including HALTED, mid-DRAIN or mid-stall, SHALL take effect immediately; the first edge after deassertion SHALL evaluate in RUN.

Verification
REQ-023 Load-use: E_icode=5, E_dstM=2, d_srcB=2, D_icode=6 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; stall_cnt 0->1 after one edge.
REQ-024 Mispredict: E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0; with e_Cnd=1 all outputs 0; mispred_cnt increments once.
REQ-025 Ret sequence: RET successively in D, E and M for 3 cycles -> F_stall=1 and D_bubble=1 each cycle; then RET with E_icode=B, E_dstM=4, d_srcA=4 -> D_bubble=0, E_bubble=1.
REQ-026 Exception drain: m_stat=3 for one edge -> state=1, F_stall=1, M_bubble=1; next W_stat=3 -> state=2, halted=1, halt_code=3, W_stall=1; cycle_cnt and retire_cnt frozen for 10 further cycles.
REQ-027 Saturation and reset: preload retire_cnt to 32'hFFFFFFFE, retire 3 AOK instructions -> 32'hFFFFFFFF; assert rst between clock edges -> counters=0, state=0, bubbles=1 immediately.
